// File: rtl/fetch_unit.sv
// fetch_unit: program counter plus a single-outstanding instruction fetch FSM with an ack timeout.
// Optional FETCH_PC_BOUNDS_EN: PC saturates at its maximum and raises a sticky Pc_Fault instead of wrapping.
`timescale 1ns/1ps

module fetch_unit #(
   parameter int INST_WIDTH  = 21,
   parameter int ADDR_WIDTH  = 8,
   parameter int ACK_TIMEOUT = 15
) (
   input  logic                  Clk,
   input  logic                  Reset,
   input  logic                  PC_Clr,
   input  logic                  PC_Load,
   input  logic                  PC_Inc,
   input  logic                  IR_Load,
   output logic                  Inst_Req,
   output logic [ADDR_WIDTH-1:0] Inst_Addr,
   input  logic [INST_WIDTH-1:0] Inst_Data,
   input  logic                  Inst_Ack,
   output logic [2:0]            Opcode,
   output logic [5:0]            Dest_Reg,
   output logic [5:0]            Source_Reg1,
   output logic [5:0]            Source_Reg2,
   output logic [ADDR_WIDTH-1:0] PC,
`ifdef FETCH_PC_BOUNDS_EN
   output logic                  Pc_Fault,
`endif
   output logic                  Fetch_Busy,
   output logic                  Fetch_Done,
   output logic                  Fetch_Err
);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE, S_ERR} state_t;

   localparam logic [7:0]            TIMEOUT_CNT = 8'(ACK_TIMEOUT);
   localparam logic [ADDR_WIDTH-1:0] PC_ONE      = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

   state_t                state;
   state_t                next_state;
   logic [INST_WIDTH-1:0] ir;
   logic [7:0]            wait_cnt;
   logic [7:0]            wait_cnt_inc;
   logic                  timeout;
   logic [ADDR_WIDTH-1:0] load_val;

   assign Opcode      = ir[20:18];
   assign Dest_Reg    = ir[17:12];
   assign Source_Reg1 = ir[11:6];
   assign Source_Reg2 = ir[5:0];

   assign wait_cnt_inc = wait_cnt + 8'd1;
   assign timeout      = !Inst_Ack && (wait_cnt_inc == TIMEOUT_CNT);

   // Jump target is the destination field, zero-extended or truncated to the PC width.
   generate
      if (ADDR_WIDTH > 6) begin : g_load_ext
         assign load_val = {{(ADDR_WIDTH-6){1'b0}}, Dest_Reg};
      end else begin : g_load_trunc
         assign load_val = Dest_Reg[ADDR_WIDTH-1:0];
      end
   endgenerate

`ifdef FETCH_PC_BOUNDS_EN
   localparam logic [ADDR_WIDTH-1:0] PC_MAX = '1;

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         PC       <= '0;
         Pc_Fault <= 1'b0;
      end else if (PC_Clr) begin
         PC       <= '0;
         Pc_Fault <= 1'b0;
      end else if (PC_Load) begin
         PC       <= load_val;
         Pc_Fault <= 1'b0;
      end else if (PC_Inc) begin
         if (PC == PC_MAX) begin
            Pc_Fault <= 1'b1;
         end else begin
            PC <= PC + PC_ONE;
         end
      end
   end
`else
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         PC <= '0;
      end else if (PC_Clr) begin
         PC <= '0;
      end else if (PC_Load) begin
         PC <= load_val;
      end else if (PC_Inc) begin
         PC <= PC + PC_ONE;
      end
   end
`endif

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state <= S_IDLE;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state = state;
      unique case (state)
         S_IDLE: if (IR_Load) next_state = S_WAIT;
         S_WAIT: begin
            if (Inst_Ack) begin
               next_state = S_DONE;
            end else if (timeout) begin
               next_state = S_ERR;
            end
         end
         S_DONE: next_state = S_IDLE;
         S_ERR:  next_state = S_IDLE;
         default: next_state = S_IDLE;
      endcase
   end

   always_comb begin
      Fetch_Busy = 1'b0;
      Fetch_Done = 1'b0;
      Fetch_Err  = 1'b0;
      unique case (state)
         S_WAIT: Fetch_Busy = 1'b1;
         S_DONE: begin
            Fetch_Busy = 1'b1;
            Fetch_Done = 1'b1;
         end
         S_ERR: begin
            Fetch_Busy = 1'b1;
            Fetch_Err  = 1'b1;
         end
         default: ;
      endcase
   end

   // The address is latched at request time so later PC commands cannot disturb an open fetch.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         ir        <= '0;
         Inst_Addr <= '0;
         Inst_Req  <= 1'b0;
         wait_cnt  <= '0;
      end else begin
         unique case (state)
            S_IDLE: begin
               if (IR_Load) begin
                  Inst_Addr <= PC;
                  Inst_Req  <= 1'b1;
                  wait_cnt  <= '0;
               end
            end
            S_WAIT: begin
               if (Inst_Ack) begin
                  ir       <= Inst_Data;
                  Inst_Req <= 1'b0;
               end else begin
                  wait_cnt <= wait_cnt_inc;
                  if (timeout) Inst_Req <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: randomized self-checking bench for fetch_unit against a transaction-level model.
// Build with FETCH_PC_BOUNDS_EN defined to exercise the saturating PC and Pc_Fault.
`timescale 1ns/1ps

module tb_fetch_unit;

   localparam int IW = 21;
   localparam int AW = 8;
   localparam int TO = 15;

   logic          Clk = 1'b0;
   logic          Reset, PC_Clr, PC_Load, PC_Inc, IR_Load, Inst_Ack;
   logic [IW-1:0] Inst_Data;
   logic          Inst_Req;
   logic [AW-1:0] Inst_Addr, PC;
   logic [2:0]    Opcode;
   logic [5:0]    Dest_Reg, Source_Reg1, Source_Reg2;
   logic          Fetch_Busy, Fetch_Done, Fetch_Err;
`ifdef FETCH_PC_BOUNDS_EN
   logic          Pc_Fault;
`endif

   int            total = 0;
   int            bad   = 0;

   // Reference state: PC as an integer, IR as the last accepted word, sticky overflow flag.
   int            m_pc;
   logic [20:0]   m_ir;
   logic          m_fault;

   fetch_unit #(.INST_WIDTH(IW), .ADDR_WIDTH(AW), .ACK_TIMEOUT(TO)) dut (
      .Clk(Clk), .Reset(Reset), .PC_Clr(PC_Clr), .PC_Load(PC_Load), .PC_Inc(PC_Inc),
      .IR_Load(IR_Load), .Inst_Req(Inst_Req), .Inst_Addr(Inst_Addr), .Inst_Data(Inst_Data),
      .Inst_Ack(Inst_Ack), .Opcode(Opcode), .Dest_Reg(Dest_Reg), .Source_Reg1(Source_Reg1),
      .Source_Reg2(Source_Reg2), .PC(PC),
`ifdef FETCH_PC_BOUNDS_EN
      .Pc_Fault(Pc_Fault),
`endif
      .Fetch_Busy(Fetch_Busy), .Fetch_Done(Fetch_Done), .Fetch_Err(Fetch_Err)
   );

   always #5 Clk = ~Clk;

   // One clock: apply the PC rule to the model with the commands present, then sample 1ns past the edge.
   task automatic step();
      int nxt;
      nxt = m_pc;
      if (PC_Clr) begin
         nxt = 0;
         m_fault = 1'b0;
      end else if (PC_Load) begin
         nxt = int'(m_ir[17:12]);
         m_fault = 1'b0;
      end else if (PC_Inc) begin
`ifdef FETCH_PC_BOUNDS_EN
         if (m_pc == 255) m_fault = 1'b1;
         else nxt = m_pc + 1;
`else
         nxt = (m_pc + 1) % 256;
`endif
      end
      @(posedge Clk);
      #1;
      m_pc = nxt;
   endtask

   task automatic random_pc_cmds();
      PC_Clr  = ($urandom_range(0, 11) == 0);
      PC_Load = ($urandom_range(0, 5) == 0);
      PC_Inc  = $urandom_range(0, 1) == 1;
   endtask

   task automatic clear_pc_cmds();
      PC_Clr  = 1'b0;
      PC_Load = 1'b0;
      PC_Inc  = 1'b0;
   endtask

   task automatic test_reset();
      Reset = 1'b1;
      clear_pc_cmds();
      IR_Load = 1'b0;
      Inst_Ack = 1'b0;
      Inst_Data = '0;
      m_pc = 0;
      m_ir = '0;
      m_fault = 1'b0;
      repeat (2) @(posedge Clk);
      #1;
      total++;
      if ({Inst_Req, Inst_Addr, PC, Opcode, Dest_Reg, Source_Reg1, Source_Reg2,
           Fetch_Busy, Fetch_Done, Fetch_Err} !== 41'd0) begin
         bad++;
         $display("[TB] FAIL reset_outputs: req=%b addr=%0d pc=%0d op=%0d busy=%b done=%b err=%b, all must be 0",
                  Inst_Req, Inst_Addr, PC, Opcode, Fetch_Busy, Fetch_Done, Fetch_Err);
      end
`ifdef FETCH_PC_BOUNDS_EN
      total++;
      if (Pc_Fault !== 1'b0) begin
         bad++;
         $display("[TB] FAIL reset_fault: got %b expected 0", Pc_Fault);
      end
`endif
      Reset = 1'b0;
   endtask

   task automatic test_pc_commands();
      PC_Inc = 1'b1;
      repeat (3) step();
      PC_Inc = 1'b0;
      total++;
      if (PC !== 8'd3) begin
         bad++;
         $display("[TB] FAIL pc_inc3: got %0d expected 3", PC);
      end
      PC_Clr = 1'b1;
      PC_Inc = 1'b1;
      step();
      clear_pc_cmds();
      total++;
      if (PC !== 8'd0) begin
         bad++;
         $display("[TB] FAIL pc_clr_priority: got %0d expected 0", PC);
      end
      for (int i = 0; i < 60; i++) begin
         random_pc_cmds();
         step();
         total++;
         if (PC !== 8'(m_pc)) begin
            bad++;
            $display("[TB] FAIL pc_random[%0d]: got %0d expected %0d", i, PC, m_pc);
         end
      end
      clear_pc_cmds();
   endtask

   task automatic test_fetch_directed();
      PC_Clr = 1'b1;
      step();
      PC_Clr = 1'b0;
      PC_Inc = 1'b1;
      repeat (5) step();
      PC_Inc = 1'b0;
      IR_Load = 1'b1;
      step();
      IR_Load = 1'b0;
      total++;
      if ({Inst_Req, Inst_Addr, Fetch_Busy} !== {1'b1, 8'd5, 1'b1}) begin
         bad++;
         $display("[TB] FAIL fetch_issue: req=%b addr=%0d busy=%b expected req=1 addr=5 busy=1",
                  Inst_Req, Inst_Addr, Fetch_Busy);
      end
      step();
      total++;
      if ({Inst_Req, Fetch_Done} !== 2'b10) begin
         bad++;
         $display("[TB] FAIL fetch_wait: req=%b done=%b expected req=1 done=0", Inst_Req, Fetch_Done);
      end
      Inst_Ack = 1'b1;
      Inst_Data = 21'b101_000111_000010_000011;
      step();
      m_ir = 21'b101_000111_000010_000011;
      Inst_Ack = 1'b0;
      Inst_Data = '0;
      total++;
      if ({Opcode, Dest_Reg, Source_Reg1, Source_Reg2} !== {3'b101, 6'd7, 6'd2, 6'd3}) begin
         bad++;
         $display("[TB] FAIL fetch_fields: op=%b dest=%0d s1=%0d s2=%0d expected op=101 dest=7 s1=2 s2=3",
                  Opcode, Dest_Reg, Source_Reg1, Source_Reg2);
      end
      total++;
      if ({Fetch_Done, Inst_Req, Fetch_Err} !== 3'b100) begin
         bad++;
         $display("[TB] FAIL fetch_done_pulse: done=%b req=%b err=%b expected 1 0 0",
                  Fetch_Done, Inst_Req, Fetch_Err);
      end
      step();
      total++;
      if ({Fetch_Done, Fetch_Busy} !== 2'b00) begin
         bad++;
         $display("[TB] FAIL fetch_done_one_cycle: done=%b busy=%b expected 0 0", Fetch_Done, Fetch_Busy);
      end
   endtask

   task automatic test_timeout();
      int n;
      n = 0;
      IR_Load = 1'b1;
      step();
      IR_Load = 1'b0;
      while (Inst_Req === 1'b1 && n < 40) begin
         step();
         n++;
      end
      total++;
      if (n !== TO) begin
         bad++;
         $display("[TB] FAIL timeout_cycles: req held %0d cycles expected %0d", n, TO);
      end
      total++;
      if ({Fetch_Err, Fetch_Done, Fetch_Busy} !== 3'b101) begin
         bad++;
         $display("[TB] FAIL timeout_err: err=%b done=%b busy=%b expected 1 0 1", Fetch_Err, Fetch_Done, Fetch_Busy);
      end
      total++;
      if ({Opcode, Dest_Reg, Source_Reg1, Source_Reg2} !== m_ir) begin
         bad++;
         $display("[TB] FAIL timeout_ir_kept: got %h expected %h",
                  {Opcode, Dest_Reg, Source_Reg1, Source_Reg2}, m_ir);
      end
      step();
      total++;
      if ({Fetch_Err, Fetch_Busy} !== 2'b00) begin
         bad++;
         $display("[TB] FAIL timeout_err_one_cycle: err=%b busy=%b expected 0 0", Fetch_Err, Fetch_Busy);
      end
   endtask

   task automatic test_ignore_during_wait();
      logic [7:0]  addr;
      logic [20:0] data;
      addr = 8'(m_pc);
      IR_Load = 1'b1;
      step();
      IR_Load = 1'b0;
      step();
      IR_Load = 1'b1;
      PC_Load = 1'b1;
      step();
      IR_Load = 1'b0;
      PC_Load = 1'b0;
      total++;
      if ({PC, Inst_Addr, Inst_Req} !== {8'd7, addr, 1'b1}) begin
         bad++;
         $display("[TB] FAIL wait_pc_load: pc=%0d addr=%0d req=%b expected pc=7 addr=%0d req=1",
                  PC, Inst_Addr, Inst_Req, addr);
      end
      data = 21'($urandom());
      Inst_Ack = 1'b1;
      Inst_Data = data;
      step();
      m_ir = data;
      Inst_Ack = 1'b0;
      total++;
      if ({Opcode, Dest_Reg, Source_Reg1, Source_Reg2} !== data) begin
         bad++;
         $display("[TB] FAIL wait_ack_data: got %h expected %h", {Opcode, Dest_Reg, Source_Reg1, Source_Reg2}, data);
      end
      repeat (3) step();
      total++;
      if ({Inst_Req, Fetch_Busy} !== 2'b00) begin
         bad++;
         $display("[TB] FAIL no_queued_request: req=%b busy=%b expected 0 0", Inst_Req, Fetch_Busy);
      end
   endtask

   task automatic test_random_fetch();
      int          ack_at;
      int          fin;
      logic [7:0]  exp_addr;
      logic [20:0] data;
      for (int t = 0; t < 25; t++) begin
         for (int j = 0; j < $urandom_range(0, 3); j++) begin
            random_pc_cmds();
            Inst_Ack = $urandom_range(0, 1) == 1;
            Inst_Data = 21'($urandom());
            step();
         end
         Inst_Ack = 1'b0;
         total++;
         if ({Opcode, Dest_Reg, Source_Reg1, Source_Reg2} !== m_ir) begin
            bad++;
            $display("[TB] FAIL stray_ack_ignored[%0d]: got %h expected %h", t,
                     {Opcode, Dest_Reg, Source_Reg1, Source_Reg2}, m_ir);
         end
         exp_addr = 8'(m_pc);
         random_pc_cmds();
         IR_Load = 1'b1;
         step();
         IR_Load = 1'b0;
         total++;
         if ({Inst_Req, Inst_Addr} !== {1'b1, exp_addr}) begin
            bad++;
            $display("[TB] FAIL rand_issue[%0d]: req=%b addr=%0d expected req=1 addr=%0d", t, Inst_Req, Inst_Addr, exp_addr);
         end
         ack_at = $urandom_range(1, 20);
         fin = (ack_at < TO) ? ack_at : TO;
         data = 21'($urandom());
         for (int k = 1; k <= fin; k++) begin
            random_pc_cmds();
            Inst_Ack = (k == ack_at);
            Inst_Data = (k == ack_at) ? data : 21'($urandom());
            step();
            if (k == ack_at) m_ir = data;
            if (k < fin) begin
               total++;
               if ({Inst_Req, Fetch_Done, Fetch_Err, Inst_Addr} !== {3'b100, exp_addr}) begin
                  bad++;
                  $display("[TB] FAIL rand_wait[%0d.%0d]: req=%b done=%b err=%b addr=%0d expected 1 0 0 addr=%0d",
                           t, k, Inst_Req, Fetch_Done, Fetch_Err, Inst_Addr, exp_addr);
               end
            end
         end
         Inst_Ack = 1'b0;
         total++;
         if ({Inst_Req, Fetch_Done, Fetch_Err} !== {1'b0, ack_at <= TO, ack_at > TO}) begin
            bad++;
            $display("[TB] FAIL rand_outcome[%0d]: req=%b done=%b err=%b with ack at %0d", t,
                     Inst_Req, Fetch_Done, Fetch_Err, ack_at);
         end
         total++;
         if ({Opcode, Dest_Reg, Source_Reg1, Source_Reg2, PC} !== {m_ir, 8'(m_pc)}) begin
            bad++;
            $display("[TB] FAIL rand_ir_pc[%0d]: ir=%h pc=%0d expected ir=%h pc=%0d", t,
                     {Opcode, Dest_Reg, Source_Reg1, Source_Reg2}, PC, m_ir, m_pc);
         end
         random_pc_cmds();
         step();
         total++;
         if ({Fetch_Done, Fetch_Err, Fetch_Busy, PC} !== {3'b000, 8'(m_pc)}) begin
            bad++;
            $display("[TB] FAIL rand_return_idle[%0d]: done=%b err=%b busy=%b pc=%0d expected 0 0 0 pc=%0d", t,
                     Fetch_Done, Fetch_Err, Fetch_Busy, PC, m_pc);
         end
      end
      clear_pc_cmds();
   endtask

   task automatic test_reset_mid_wait();
      logic [20:0] data;
      IR_Load = 1'b1;
      step();
      IR_Load = 1'b0;
      step();
      #2;
      Reset = 1'b1;
      #1;
      m_pc = 0;
      m_ir = '0;
      m_fault = 1'b0;
      total++;
      if ({Inst_Req, Inst_Addr, PC, Opcode, Dest_Reg, Source_Reg1, Source_Reg2,
           Fetch_Busy, Fetch_Done, Fetch_Err} !== 41'd0) begin
         bad++;
         $display("[TB] FAIL async_reset: req=%b addr=%0d pc=%0d op=%0d busy=%b, all must be 0",
                  Inst_Req, Inst_Addr, PC, Opcode, Fetch_Busy);
      end
      @(posedge Clk);
      #2;
      Reset = 1'b0;
      Inst_Ack = 1'b1;
      Inst_Data = 21'($urandom()) | 21'h100000;
      step();
      Inst_Ack = 1'b0;
      total++;
      if ({Inst_Req, Fetch_Busy, Opcode, Dest_Reg, Source_Reg1, Source_Reg2} !== 23'd0) begin
         bad++;
         $display("[TB] FAIL late_ack_ignored: req=%b busy=%b ir=%h expected all 0", Inst_Req, Fetch_Busy,
                  {Opcode, Dest_Reg, Source_Reg1, Source_Reg2});
      end
      #2;
      Reset = 1'b1;
      @(posedge Clk);
      #2;
      Reset = 1'b0;
      IR_Load = 1'b1;
      step();
      IR_Load = 1'b0;
      total++;
      if ({Inst_Req, Inst_Addr} !== {1'b1, 8'd0}) begin
         bad++;
         $display("[TB] FAIL first_load_after_reset: req=%b addr=%0d expected req=1 addr=0", Inst_Req, Inst_Addr);
      end
      data = 21'($urandom());
      Inst_Ack = 1'b1;
      Inst_Data = data;
      step();
      m_ir = data;
      Inst_Ack = 1'b0;
      step();
   endtask

   task automatic test_pc_wrap();
      PC_Clr = 1'b1;
      step();
      PC_Clr = 1'b0;
      PC_Inc = 1'b1;
      repeat (255) step();
      PC_Inc = 1'b0;
      total++;
      if (PC !== 8'd255) begin
         bad++;
         $display("[TB] FAIL pc_reach_max: got %0d expected 255", PC);
      end
      PC_Inc = 1'b1;
      step();
      PC_Inc = 1'b0;
`ifdef FETCH_PC_BOUNDS_EN
      total++;
      if ({PC, Pc_Fault} !== {8'd255, 1'b1}) begin
         bad++;
         $display("[TB] FAIL pc_saturate: pc=%0d fault=%b expected pc=255 fault=1", PC, Pc_Fault);
      end
      step();
      total++;
      if (Pc_Fault !== m_fault) begin
         bad++;
         $display("[TB] FAIL pc_fault_sticky: got %b expected %b", Pc_Fault, m_fault);
      end
      PC_Clr = 1'b1;
      step();
      PC_Clr = 1'b0;
      total++;
      if ({PC, Pc_Fault} !== {8'd0, 1'b0}) begin
         bad++;
         $display("[TB] FAIL pc_fault_clear: pc=%0d fault=%b expected pc=0 fault=0", PC, Pc_Fault);
      end
`else
      total++;
      if (PC !== 8'd0) begin
         bad++;
         $display("[TB] FAIL pc_wrap: got %0d expected 0", PC);
      end
`endif
      total++;
      if (PC !== 8'(m_pc)) begin
         bad++;
         $display("[TB] FAIL pc_wrap_model: got %0d expected %0d", PC, m_pc);
      end
   endtask

   initial begin
      test_reset();
      test_pc_commands();
      test_fetch_directed();
      test_timeout();
      test_ignore_during_wait();
      test_random_fetch();
      test_reset_mid_wait();
      test_pc_wrap();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter INST_WIDTH, default 21: instruction word width.
REQ-002 Parameter ADDR_WIDTH, default 8: program counter and instruction address width.
REQ-003 Parameter ACK_TIMEOUT, default 15: maximum wait cycles for Inst_Ack before the fetch aborts; legal range 1..255.
REQ-004 Clk  in  1  single clock; all state updates on the rising edge.
REQ-005 Reset  in  1  asynchronous, active-high reset.
REQ-006 PC_Clr, PC_Load, PC_Inc  in  1 each  program counter commands from the controller.
REQ-007 IR_Load  in  1  fetch request from the controller.
REQ-008 Inst_Req  out  1  instruction-memory read request, registered.
REQ-009 Inst_Addr  out  ADDR_WIDTH  instruction-memory address, registered.
REQ-010 Inst_Data  in  INST_WIDTH  instruction-memory read data, valid when Inst_Ack=1.
REQ-011 Inst_Ack  in  1  instruction-memory read acknowledge.
REQ-012 Opcode  out  3  IR[20:18], fed to the controller.
REQ-013 Dest_Reg, Source_Reg1, Source_Reg2  out  6 each  IR[17:12], IR[11:6], IR[5:0].
REQ-014 PC  out  ADDR_WIDTH  current program counter.
REQ-015 Fetch_Busy, Fetch_Done, Fetch_Err  out  1 each  fetch status.

Function
REQ-016 PC priority per cycle: PC_Clr -> 0; else PC_Load -> Dest_Reg[ADDR_WIDTH-1:0] of the current IR, zero-extended if ADDR_WIDTH>6; else PC_Inc -> PC+1; else hold.
REQ-017 PC commands are honoured in every FSM state; Inst_Addr is unaffected by PC changes after a request is issued.
REQ-018 FSM states: IDLE, WAIT, DONE, ERR.
REQ-019 IDLE: when IR_Load=1, the block registers Inst_Addr<=PC, Inst_Req<=1, clears the wait counter, and goes to WAIT.
REQ-020 WAIT: Inst_Req stays 1.
- Inst_Ack=1: IR<=Inst_Data, Inst_Req<=0, go to DONE.
- Inst_Ack=0: the counter increments; when it reaches ACK_TIMEOUT, Inst_Req<=0, go to ERR, IR unchanged.
REQ-021 DONE: Fetch_Done=1 for exactly one cycle, then IDLE.
REQ-022 ERR: Fetch_Err=1 for exactly one cycle, then IDLE.
REQ-023 Fetch_Busy=1 in WAIT, DONE and ERR, and 0 in IDLE.
REQ-024 IR_Load while not in IDLE is ignored; it is not queued.
REQ-025 Fetch latency: IR_Load sampled in cycle N, Inst_Req visible in N+1; Inst_Ack sampled in cycle M updates Opcode in M+1 and raises Fetch_Done in M+1.
REQ-026 Inst_Ack while Inst_Req=0 is ignored.
REQ-027 PC_Inc at the maximum address wraps PC to 0 (default build, see REQ-032).
REQ-028 Opcode and the register fields are combinational slices of IR; IR changes only on an accepted Inst_Ack or on Reset.

Reset
REQ-029 Reset=1 forces immediately, independent of Clk: state=IDLE, PC=0, IR=0, Inst_Addr=0, Inst_Req=0, counter=0, Fetch_Busy=0, Fetch_Done=0, Fetch_Err=0, Pc_Fault=0.
REQ-030 Reset during WAIT abandons the fetch; a late Inst_Ack after release is ignored per REQ-026.
REQ-031 The first IR_Load after Reset release is accepted in the first rising edge with Reset=0.

Configuration
REQ-032 Macro FETCH_PC_BOUNDS_EN selects PC overflow handling.
- Defined: adds output Pc_Fault (out, 1). PC_Inc at the maximum address holds PC and sets Pc_Fault sticky. Only PC_Clr, PC_Load or Reset clear it.
- Undefined: no Pc_Fault port; PC wraps to 0 per REQ-027.

Verification
REQ-033 Reset, then PC_Inc for 3 cycles -> PC=3; PC_Clr and PC_Inc asserted together -> PC=0.
REQ-034 IR_Load with PC=5, Inst_Ack 2 cycles after Inst_Req, Inst_Data=21'b101_000111_000010_000011 -> Inst_Addr=5, Opcode=101, Dest_Reg=7, Fetch_Done pulses one cycle.
REQ-035 IR_Load with Inst_Ack held 0 -> Inst_Req drops after 15 wait cycles, Fetch_Err pulses one cycle, IR unchanged.
REQ-036 Second IR_Load during WAIT -> no second request; PC_Load during WAIT -> PC=Dest_Reg while Inst_Addr holds.
REQ-037 Reset asserted mid-WAIT -> all outputs 0 asynchronously; a stray Inst_Ack afterwards leaves IR=0.
REQ-038 PC=255, PC_Inc -> PC=0 without FETCH_PC_BOUNDS_EN; PC=255 and Pc_Fault=1 with it.
